serial_add_ctrl: RTL

//   Bit-serial adder controller. Sequences one FullAdder instance over WIDTH clock

---
 rtl/serial_add_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one single-bit full adder is stepped LSB first over WIDTH
// cycles to form a + b + cin. The requester sees a start/done handshake; the
// result is held on sum/cout until the next completion or reset.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// SHIFT | one operand bit pair per cycle through the full adder, WIDTH cycles
// DONE  | result register loaded from the shift register; done pulses next cycle

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             carry_q;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_co;

   full_adder u_fa (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic; start is only looked at in IDLE so it is never queued.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = SHIFT;
         SHIFT:   if (cnt == LAST) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Moore output: busy depends on state only, so no input reaches an output.
   always_comb begin
      busy = (state == SHIFT);
   end

   // Datapath: operand capture, serial shifting, and the held result registers.
   // The new sum bit enters res_sh at the MSB so the first bit computed ends in bit 0.
   // Written as a shift/OR so that WIDTH=1 needs no zero-width slice.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         res_sh  <= '0;
         carry_q <= 1'b0;
         cnt     <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= (state == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh    <= a;
                  b_sh    <= b;
                  carry_q <= cin;
                  cnt     <= '0;
               end
            end
            SHIFT: begin
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               res_sh  <= (res_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
               carry_q <= fa_co;
               cnt     <= cnt + CW'(1);
            end
            DONE: begin
               sum  <= res_sh;
               cout <= carry_q;
            end
            default: ;
         endcase
      end
   end

endmodule
